hwpe_ctrl_periph2reqrsp: RTL and testbench
==========================================

HWPE_CTRL_PERIPH2REQRSP -- requirements
Module: hwpe_ctrl_periph2reqrsp

Interface
REQ-001 Parameter AddrWidth, default 32: address width on both sides.
REQ-002 Parameter DataWidth, default 32: data width on both sides; multiple of 8; strobe width DataWidth/8.
REQ-003 Parameter IdWidth, default 8: periph transaction ID width.
REQ-004 Parameter MaxOutstanding, default 4: ID FIFO depth, i.e. maximum in-flight transactions; >=1; need not be a power of two.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 periph_req_i  in  1  request; upstream holds it and all payload stable until granted.
REQ-008 periph_gnt_o  out  1  grant.
REQ-009 periph_add_i  in  AddrWidth  address.
REQ-010 periph_wen_i  in  1  1 = read, 0 = write.
REQ-011 periph_be_i  in  DataWidth/8  byte enables.
REQ-012 periph_data_i  in  DataWidth  write data.
REQ-013 periph_id_i  in  IdWidth  transaction ID.
REQ-014 periph_r_data_o / periph_r_valid_o / periph_r_id_o  out  DataWidth/1/IdWidth  response data, pulse and ID.
REQ-015 q_addr_o / q_write_o / q_strb_o / q_data_o  out  AddrWidth/1/DataWidth/8/DataWidth  reqrsp request payload.
REQ-016 q_valid_o  out  1, q_ready_i  in  1: reqrsp request handshake.
REQ-017 p_data_i  in  DataWidth, p_valid_i  in  1, p_ready_o  out  1: reqrsp response channel.
REQ-018 busy_o  out  1: at least one transaction outstanding.
REQ-019 err_o  out  1: sticky protocol error flag.

Function
REQ-020 Every granted request, read or write, receives exactly one p response and exactly one periph_r_valid_o pulse.
REQ-021 Full = outstanding count == MaxOutstanding; count width $clog2(MaxOutstanding+1).
REQ-022 q_valid_o = periph_req_i & ~full, combinational; q_addr_o = periph_add_i, q_write_o = ~periph_wen_i, q_strb_o = periph_be_i, q_data_o = periph_data_i.
REQ-023 periph_gnt_o = q_valid_o & q_ready_i; request handshake (push) occurs exactly in this cycle.
REQ-024 On push, periph_id_i is written to the ID FIFO tail and the count increments.
REQ-025 p_ready_o is constant 1; the periph side has no response back-pressure.
REQ-026 Pop = p_valid_i & FIFO non-empty, evaluated on the registered pre-edge count; a push in the same cycle is not visible to that pop.
REQ-027 On pop, periph_r_data_o <= p_data_i, periph_r_id_o <= FIFO head, periph_r_valid_o <= 1 for exactly one cycle. Latency is one cycle from p handshake to r_valid.
REQ-028 periph_r_valid_o <= 0 in every cycle without a pop; r_data and r_id hold their last value.
REQ-029 Simultaneous push and pop leaves the count unchanged; both FIFO pointers advance.
REQ-030 Full gating uses the pre-edge count: when full, no grant is issued even if a pop occurs in the same cycle.
REQ-031 FIFO pointers wrap from MaxOutstanding-1 to 0.
REQ-032 p_valid_i with an empty FIFO: err_o <= 1 sticky, no pop, no r_valid, count unchanged.
REQ-033 busy_o = (count != 0), registered-state derived.
REQ-034 Responses are returned in request order; the target is in-order.

Reset
REQ-035 Asynchronous assertion of rst_ni clears count, both FIFO pointers, periph_r_valid_o, periph_r_data_o, periph_r_id_o and err_o to 0 immediately.
REQ-036 Reset mid-operation drops all outstanding IDs; after release busy_o=0, full=0, and a late p_valid_i sets err_o.
REQ-037 Combinational outputs follow inputs during reset, with count=0 so q_valid_o = periph_req_i.

Verification
REQ-038 Single read: add=0x10, id=0x5, q_ready=1, response p_data=0xCAFE two cycles later -> gnt in cycle 0, r_valid one cycle after p_valid with r_data=0xCAFE and r_id=0x5, busy 1->0.
REQ-039 Fill: MaxOutstanding=4, ids 1..5 back-to-back, no responses -> 4 grants, 5th req held with gnt=0 and q_valid=0; one response -> r_id=1; 5th granted the cycle after.
REQ-040 Back-pressure: q_ready=0 for 3 cycles with req held -> no grant and count unchanged; q_ready=1 -> grant in that cycle.
REQ-041 Simultaneous push and pop at count=2 -> count stays 2; ordering preserved across pointer wrap over 10 transactions, r_ids matching issue order.
REQ-042 Spurious p_valid with count=0 -> err_o=1, no r_valid; err_o persists until rst_ni low.
REQ-043 Reset asserted with 3 outstanding -> r_valid, busy and err read 0 asynchronously; after release, a new request with id=0x7 completes with r_id=0x7.

Source files
------------

// File: rtl/hwpe_ctrl_periph2reqrsp.sv
// Bridges a HWPE periph-style request/grant port onto a reqrsp request/response pair.
// IDs of granted requests are kept in an in-order FIFO and attached to the returning responses.
module hwpe_ctrl_periph2reqrsp #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 8,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   periph_req_i,
  output logic                   periph_gnt_o,
  input  logic [AddrWidth-1:0]   periph_add_i,
  input  logic                   periph_wen_i,
  input  logic [DataWidth/8-1:0] periph_be_i,
  input  logic [DataWidth-1:0]   periph_data_i,
  input  logic [IdWidth-1:0]     periph_id_i,
  output logic [DataWidth-1:0]   periph_r_data_o,
  output logic                   periph_r_valid_o,
  output logic [IdWidth-1:0]     periph_r_id_o,
  output logic [AddrWidth-1:0]   q_addr_o,
  output logic                   q_write_o,
  output logic [DataWidth/8-1:0] q_strb_o,
  output logic [DataWidth-1:0]   q_data_o,
  output logic                   q_valid_o,
  input  logic                   q_ready_i,
  input  logic [DataWidth-1:0]   p_data_i,
  input  logic                   p_valid_i,
  output logic                   p_ready_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstanding);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MaxOutstanding - 1);

  // Depth need not be a power of two, so wrap explicitly at the last slot.
  function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] ptr);
    logic [PtrWidth-1:0] nxt;
    if (ptr == PtrLast) begin
      nxt = '0;
    end else begin
      nxt = ptr + PtrWidth'(1);
    end
    return nxt;
  endfunction

  logic [CntWidth-1:0] count;
  logic [CntWidth-1:0] count_next;
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic [IdWidth-1:0]  id_mem [MaxOutstanding];
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                r_valid;
  logic [DataWidth-1:0] r_data;
  logic [IdWidth-1:0]  r_id;
  logic                err;

  assign full  = (count == CntMax);
  assign empty = (count == '0);

  assign q_valid_o    = periph_req_i & ~full;
  assign q_addr_o     = periph_add_i;
  assign q_write_o    = ~periph_wen_i;
  assign q_strb_o     = periph_be_i;
  assign q_data_o     = periph_data_i;
  assign periph_gnt_o = q_valid_o & q_ready_i;
  assign p_ready_o    = 1'b1;
  assign busy_o       = ~empty;

  // Pop sees only the pre-edge count: a same-cycle push cannot satisfy it.
  assign push = periph_gnt_o;
  assign pop  = p_valid_i & ~empty;

  assign periph_r_valid_o = r_valid;
  assign periph_r_data_o  = r_data;
  assign periph_r_id_o    = r_id;
  assign err_o            = err;

  // Outstanding counter update.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CntWidth'(1);
      2'b01:   count_next = count - CntWidth'(1);
      default: count_next = count;
    endcase
  end

  // Counter and FIFO pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
    end
  end

  // ID storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        id_mem[i] <= '0;
      end
    end else if (push) begin
      id_mem[wr_ptr] <= periph_id_i;
    end
  end

  // Response path: one-cycle pulse carrying data and the head ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
    end else begin
      r_valid <= pop;
      if (pop) begin
        r_data <= p_data_i;
        r_id   <= id_mem[rd_ptr];
      end
    end
  end

  // A response with nothing outstanding is a protocol violation; stays set until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err <= 1'b0;
    end else if (p_valid_i && empty) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_periph2reqrsp.sv
// Directed bench for hwpe_ctrl_periph2reqrsp with MaxOutstanding = 4.
// Inputs change 1 time unit after a rising edge; outputs are checked away from the edge.
module tb_hwpe_ctrl_periph2reqrsp;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  id;
  logic [31:0] r_data;
  logic        r_valid;
  logic [7:0]  r_id;
  logic [31:0] q_addr;
  logic        q_write;
  logic [3:0]  q_strb;
  logic [31:0] q_data;
  logic        q_valid;
  logic        q_ready;
  logic [31:0] p_data;
  logic        p_valid;
  logic        p_ready;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  hwpe_ctrl_periph2reqrsp #(
    .AddrWidth(32), .DataWidth(32), .IdWidth(8), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .periph_req_i(req), .periph_gnt_o(gnt), .periph_add_i(add), .periph_wen_i(wen),
    .periph_be_i(be), .periph_data_i(wdata), .periph_id_i(id),
    .periph_r_data_o(r_data), .periph_r_valid_o(r_valid), .periph_r_id_o(r_id),
    .q_addr_o(q_addr), .q_write_o(q_write), .q_strb_o(q_strb), .q_data_o(q_data),
    .q_valid_o(q_valid), .q_ready_i(q_ready),
    .p_data_i(p_data), .p_valid_i(p_valid), .p_ready_o(p_ready),
    .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b1; q_ready = 1'b1; add = 32'h0; wen = 1'b1; be = 4'hF;
    wdata = 32'h0; id = 8'h0; p_valid = 1'b0; p_data = 32'h0;
    #1;
    chk("rst_q_valid", 64'(q_valid), 64'd1);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_r_data", 64'(r_data), 64'd0);
    chk("rst_r_id", 64'(r_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_p_ready", 64'(p_ready), 64'd1);
    req = 1'b0;
    #20;
    rst_n = 1'b1;
    tick();

    // Single read.
    add = 32'h10; wen = 1'b1; id = 8'h05; req = 1'b1;
    #1;
    chk("rd_gnt", 64'(gnt), 64'd1);
    chk("rd_q_write", 64'(q_write), 64'd0);
    chk("rd_q_addr", 64'(q_addr), 64'h10);
    tick();
    req = 1'b0;
    chk("rd_busy1", 64'(busy), 64'd1);
    tick();
    p_valid = 1'b1; p_data = 32'hCAFE;
    #1;
    chk("rd_r_valid_early", 64'(r_valid), 64'd0);
    tick();
    p_valid = 1'b0;
    chk("rd_r_valid", 64'(r_valid), 64'd1);
    chk("rd_r_data", 64'(r_data), 64'hCAFE);
    chk("rd_r_id", 64'(r_id), 64'h05);
    chk("rd_busy0", 64'(busy), 64'd0);
    tick();
    chk("rd_r_valid_drop", 64'(r_valid), 64'd0);
    chk("rd_r_data_hold", 64'(r_data), 64'hCAFE);

    // Fill to MaxOutstanding, fifth request stalls until a response frees a slot.
    req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      id = 8'(i);
      #1;
      chk("fill_gnt", 64'(gnt), 64'd1);
      tick();
    end
    id = 8'h05;
    #1;
    chk("full_gnt", 64'(gnt), 64'd0);
    chk("full_q_valid", 64'(q_valid), 64'd0);
    p_valid = 1'b1; p_data = 32'h1111;
    #1;
    chk("full_pop_gnt", 64'(gnt), 64'd0);
    tick();
    p_valid = 1'b0;
    chk("fill_r_valid", 64'(r_valid), 64'd1);
    chk("fill_r_id1", 64'(r_id), 64'h01);
    chk("fill_regnt", 64'(gnt), 64'd1);
    tick();
    req = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      p_valid = 1'b1; p_data = 32'h2000 + 32'(i);
      tick();
      chk("drain_r_id", 64'(r_id), 64'(i));
      chk("drain_r_data", 64'(r_data), 64'h2000 + 64'(i));
    end
    p_valid = 1'b0;
    chk("drain_busy", 64'(busy), 64'd0);

    // Back-pressure with a write request.
    req = 1'b1; wen = 1'b0; be = 4'h3; wdata = 32'hDEADBEEF; add = 32'h44; id = 8'h09;
    q_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_gnt", 64'(gnt), 64'd0);
      chk("bp_q_valid", 64'(q_valid), 64'd1);
      tick();
      chk("bp_busy", 64'(busy), 64'd0);
    end
    chk("wr_q_write", 64'(q_write), 64'd1);
    chk("wr_q_strb", 64'(q_strb), 64'h3);
    chk("wr_q_data", 64'(q_data), 64'hDEADBEEF);
    q_ready = 1'b1;
    #1;
    chk("bp_gnt_release", 64'(gnt), 64'd1);
    tick();
    req = 1'b0; wen = 1'b1; be = 4'hF;
    chk("bp_busy1", 64'(busy), 64'd1);
    p_valid = 1'b1; p_data = 32'h0;
    tick();
    p_valid = 1'b0;
    chk("wr_r_valid", 64'(r_valid), 64'd1);
    chk("wr_r_id", 64'(r_id), 64'h09);
    chk("wr_busy0", 64'(busy), 64'd0);

    // Simultaneous push/pop at count 2, ordering across pointer wrap.
    req = 1'b1;
    id = 8'h20; tick();
    id = 8'h21; tick();
    for (int i = 2; i < 10; i++) begin
      id = 8'h20 + 8'(i); p_valid = 1'b1; p_data = 32'h100 + 32'(i);
      #1;
      chk("wrap_gnt", 64'(gnt), 64'd1);
      tick();
      chk("wrap_r_valid", 64'(r_valid), 64'd1);
      chk("wrap_r_id", 64'(r_id), 64'h20 + 64'(i - 2));
      chk("wrap_r_data", 64'(r_data), 64'h100 + 64'(i));
    end
    p_valid = 1'b0;
    id = 8'h2A; #1; chk("cnt2_gnt_a", 64'(gnt), 64'd1); tick();
    id = 8'h2B; #1; chk("cnt2_gnt_b", 64'(gnt), 64'd1); tick();
    id = 8'h2C; #1; chk("cnt2_full", 64'(gnt), 64'd0);
    req = 1'b0;
    for (int i = 8; i < 12; i++) begin
      p_valid = 1'b1;
      tick();
      chk("wrap_drain_id", 64'(r_id), 64'h20 + 64'(i));
    end
    p_valid = 1'b0;
    tick();
    chk("wrap_busy0", 64'(busy), 64'd0);

    // Spurious response.
    p_valid = 1'b1; p_data = 32'hBAD;
    tick();
    p_valid = 1'b0;
    chk("spur_err", 64'(err), 64'd1);
    chk("spur_r_valid", 64'(r_valid), 64'd0);
    chk("spur_busy", 64'(busy), 64'd0);
    chk("spur_r_data_hold", 64'(r_data), 64'h100 + 64'(9));

    // Reset with 3 outstanding and r_valid high.
    req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      id = 8'h30 + 8'(i);
      tick();
    end
    req = 1'b0; p_valid = 1'b1; p_data = 32'h55;
    tick();
    p_valid = 1'b0;
    chk("pre_rst_r_valid", 64'(r_valid), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("err_sticky", 64'(err), 64'd1);
    #1;
    rst_n = 1'b0; req = 1'b1;
    #1;
    chk("arst_r_valid", 64'(r_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_r_id", 64'(r_id), 64'd0);
    chk("arst_q_valid", 64'(q_valid), 64'd1);
    req = 1'b0;
    tick();
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    chk("late_p_err", 64'(err), 64'd1);
    chk("late_p_r_valid", 64'(r_valid), 64'd0);
    req = 1'b1; id = 8'h07;
    #1;
    chk("post_rst_gnt", 64'(gnt), 64'd1);
    tick();
    req = 1'b0; p_valid = 1'b1; p_data = 32'h77;
    tick();
    p_valid = 1'b0;
    chk("post_rst_r_valid", 64'(r_valid), 64'd1);
    chk("post_rst_r_id", 64'(r_id), 64'h07);
    chk("post_rst_busy0", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
